// File: rtl/feature_buf_writer_pkg.sv
// feature_buf_writer_pkg
// Shared definitions for the feature line buffer writer and its padding
// reader partner: un-padded and padded row widths (in 64-bit words), the
// writer state encoding and the width-select decode.
package feature_buf_writer_pkg;

  // Un-padded row widths in words.
  localparam logic [8:0] W_416 = 9'd416;
  localparam logic [8:0] W_208 = 9'd208;
  localparam logic [8:0] W_104 = 9'd104;
  localparam logic [8:0] W_52  = 9'd52;
  localparam logic [8:0] W_26  = 9'd26;
  localparam logic [8:0] W_13  = 9'd13;

  // Padded counterparts (one word of padding on each side), used by the reader.
  localparam logic [8:0] P_418 = 9'd418;
  localparam logic [8:0] P_210 = 9'd210;
  localparam logic [8:0] P_106 = 9'd106;
  localparam logic [8:0] P_54  = 9'd54;
  localparam logic [8:0] P_28  = 9'd28;
  localparam logic [8:0] P_15  = 9'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } wr_state_t;

  // Unused select codes fall back to the widest row.
  function automatic logic [8:0] width_decode(input logic [2:0] sel);
    logic [8:0] w;
    case (sel)
      3'd0:    w = W_416;
      3'd1:    w = W_208;
      3'd2:    w = W_104;
      3'd3:    w = W_52;
      3'd4:    w = W_26;
      3'd5:    w = W_13;
      default: w = W_416;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/feature_buf_writer_row_col_counter.sv
// feature_row_col_counter
// Row/column position counter for one feature batch. Column counts words
// within a row and wraps at width-1; row advances on each column wrap.
// The final word of the batch returns both counters to 0, so a 128-row
// batch never overflows the 7-bit row counter.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   clear       synchronous clear (priority over advance)
//   advance     one word consumed
//   width       words per row (1..416)
//   last_row    index of the final row
//   row_cnt     current row
//   col_cnt     current word within row
//   last_word   current position is the final word of the batch
module feature_row_col_counter
  import feature_buf_writer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       advance,
  input  logic [8:0] width,
  input  logic [6:0] last_row,
  output logic [6:0] row_cnt,
  output logic [8:0] col_cnt,
  output logic       last_word
);

  logic col_end;

  assign col_end   = (col_cnt == (width - 9'd1));
  assign last_word = col_end & (row_cnt == last_row);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt <= '0;
      col_cnt <= '0;
    end else if (clear) begin
      row_cnt <= '0;
      col_cnt <= '0;
    end else if (advance) begin
      if (last_word) begin
        row_cnt <= '0;
        col_cnt <= '0;
      end else if (col_end) begin
        row_cnt <= row_cnt + 7'd1;
        col_cnt <= '0;
      end else begin
        col_cnt <= col_cnt + 9'd1;
      end
    end
  end

endmodule

// File: rtl/feature_buf_writer.sv
// feature_buf_writer
// Fills the FIFO-organised feature line buffer with one batch of
// (feature_row+1) x W un-padded words from the upstream stream, then hands
// the batch to the padding stage and waits for it to finish.
// Optional build macro: FEATURE_WR_ERR_CHECK_EN enables the sticky wr_err
// protocol checker; without it wr_err is tied low.
// Ports:
//   sclk, s_rst_n          clock, async active-low reset
//   write_start            pulse, begins a batch (IDLE only)
//   feature_col_select     row width select, latched at write_start
//   feature_row            last row index, latched at write_start
//   s_data/s_valid/s_ready upstream stream (s_ready combinational)
//   buffer_full            buffer almost-full
//   buffer_wr_en/_data     registered buffer write port
//   padding_start          pulse to padding stage
//   padding_finish         pulse from padding stage
//   write_busy             not IDLE
//   write_finish           pulse closing the batch handshake
//   wr_row_cnt/wr_col_cnt  current write position
//   wr_err                 sticky protocol error
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | waiting for write_start
// ST_LOAD  | accepting stream words into the buffer
// ST_START | final write in flight, padding_start pulse
// ST_WAIT  | batch owned by padding stage, wait padding_finish
module feature_buf_writer
  import feature_buf_writer_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              write_start,
  input  logic [2:0]        feature_col_select,
  input  logic [6:0]        feature_row,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              buffer_full,
  output logic              buffer_wr_en,
  output logic [DATA_W-1:0] buffer_wr_data,
  output logic              padding_start,
  input  logic              padding_finish,
  output logic              write_busy,
  output logic              write_finish,
  output logic [6:0]        wr_row_cnt,
  output logic [8:0]        wr_col_cnt,
  output logic              wr_err
);

  // The largest batch (128 rows x 416 words) must be countable.
  if (CNT_W < 16) begin : g_cnt_w_check
    $error("CNT_W too narrow for a 128 x 416 word batch");
  end

  wr_state_t  state, state_nxt;
  logic [8:0] w_reg;
  logic [6:0] r_reg;
  logic       accept;
  logic       ctr_last;
  logic       finish_nxt;

  assign s_ready       = (state == ST_LOAD) & ~buffer_full;
  assign accept        = s_valid & s_ready;
  assign write_busy    = (state != ST_IDLE);
  assign padding_start = (state == ST_START);

  always_comb begin
    state_nxt  = state;
    finish_nxt = 1'b0;
    unique case (state)
      ST_IDLE:  if (write_start) state_nxt = ST_LOAD;
      ST_LOAD:  if (accept && ctr_last) state_nxt = ST_START;
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (padding_finish) begin
          state_nxt  = ST_IDLE;
          finish_nxt = 1'b1;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state          <= ST_IDLE;
      w_reg          <= W_416;
      r_reg          <= '0;
      buffer_wr_en   <= 1'b0;
      buffer_wr_data <= '0;
      write_finish   <= 1'b0;
    end else begin
      state        <= state_nxt;
      buffer_wr_en <= accept;
      write_finish <= finish_nxt;
      if (accept) buffer_wr_data <= s_data;
      if (state == ST_IDLE && write_start) begin
        w_reg <= width_decode(feature_col_select);
        r_reg <= feature_row;
      end
    end
  end

  // Counters only run in LOAD; every other state holds them at 0.
  feature_row_col_counter u_counter (
    .clk       (sclk),
    .rst_n     (s_rst_n),
    .clear     (state != ST_LOAD),
    .advance   (accept),
    .width     (w_reg),
    .last_row  (r_reg),
    .row_cnt   (wr_row_cnt),
    .col_cnt   (wr_col_cnt),
    .last_word (ctr_last)
  );

`ifdef FEATURE_WR_ERR_CHECK_EN
  logic err_set;

  // A would-be write is a valid word offered in LOAD while the buffer is full.
  always_comb begin
    err_set = 1'b0;
    if (write_start && state != ST_IDLE)              err_set = 1'b1;
    if (padding_finish && state != ST_WAIT)           err_set = 1'b1;
    if (s_valid && state == ST_LOAD && buffer_full)   err_set = 1'b1;
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) wr_err <= 1'b0;
    else if (err_set) wr_err <= 1'b1;
  end
`else
  assign wr_err = 1'b0;
`endif

endmodule

// File: tb/tb_feature_buf_writer.sv
// Directed bench for feature_buf_writer.
module tb_feature_buf_writer;

  logic        sclk = 1'b0;
  logic        s_rst_n = 1'b0;
  logic        write_start = 1'b0;
  logic [2:0]  feature_col_select = '0;
  logic [6:0]  feature_row = '0;
  logic [63:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        buffer_full = 1'b0;
  logic        buffer_wr_en;
  logic [63:0] buffer_wr_data;
  logic        padding_start;
  logic        padding_finish = 1'b0;
  logic        write_busy;
  logic        write_finish;
  logic [6:0]  wr_row_cnt;
  logic [8:0]  wr_col_cnt;
  logic        wr_err;

  int total = 0;
  int bad = 0;
  logic [63:0] wq[$];

`ifdef FEATURE_WR_ERR_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  feature_buf_writer #(.DATA_W(64), .CNT_W(16)) dut (
    .sclk               (sclk),
    .s_rst_n            (s_rst_n),
    .write_start        (write_start),
    .feature_col_select (feature_col_select),
    .feature_row        (feature_row),
    .s_data             (s_data),
    .s_valid            (s_valid),
    .s_ready            (s_ready),
    .buffer_full        (buffer_full),
    .buffer_wr_en       (buffer_wr_en),
    .buffer_wr_data     (buffer_wr_data),
    .padding_start      (padding_start),
    .padding_finish     (padding_finish),
    .write_busy         (write_busy),
    .write_finish       (write_finish),
    .wr_row_cnt         (wr_row_cnt),
    .wr_col_cnt         (wr_col_cnt),
    .wr_err             (wr_err)
  );

  always #5 sclk = ~sclk;

  // Record every buffer write seen at a clock edge.
  always @(posedge sclk) if (buffer_wr_en === 1'b1) wq.push_back(buffer_wr_data);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  // mode 0: s_valid always high; 1: buffer_full 3 of every 50 cycles;
  // 2: random s_valid gaps. stop_at>0 abandons the batch after that many accepts.
  task automatic run_batch(input string tag, input logic [2:0] sel, input logic [6:0] row,
                           input int w, input logic [63:0] base, input int mode,
                           input int stop_at, input bit inject);
    int  n;
    int  k;
    int  cyc;
    int  exp_row;
    int  exp_col;
    bit  acc;
    bit  ready_bad;
    bit  cnt_bad;
    bit  data_bad;
    n = w * (int'(row) + 1);
    k = 0;
    cyc = 0;
    ready_bad = 1'b0;
    cnt_bad = 1'b0;
    data_bad = 1'b0;
    wq.delete();
    write_start = 1'b1;
    feature_col_select = sel;
    feature_row = row;
    step();
    write_start = 1'b0;
    // Changing the select inputs after the latch must have no effect.
    feature_col_select = sel ^ 3'd1;
    feature_row = row ^ 7'h55;
    while (k < n && cyc < 4 * n + 200 && !(stop_at > 0 && k == stop_at)) begin
      buffer_full = (mode == 1) && ((cyc % 50) >= 47);
      s_valid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data = base + 64'(k);
      if (inject && cyc == 3) begin
        write_start = 1'b1;
        padding_finish = 1'b1;
      end else begin
        write_start = 1'b0;
        padding_finish = 1'b0;
      end
      #1;
      if (buffer_full && s_ready !== 1'b0) ready_bad = 1'b1;
      acc = s_valid && (s_ready === 1'b1);
      step();
      if (acc) k++;
      cyc++;
      exp_row = (k == n) ? 0 : k / w;
      exp_col = (k == n) ? 0 : k % w;
      if (wr_row_cnt !== exp_row[6:0] || wr_col_cnt !== exp_col[8:0]) cnt_bad = 1'b1;
    end
    write_start = 1'b0;
    padding_finish = 1'b0;
    buffer_full = 1'b0;
    chk({tag, "_ready_low_when_full"}, 64'(ready_bad), 64'd0);
    chk({tag, "_row_col_trace"}, 64'(cnt_bad), 64'd0);
    if (stop_at > 0) begin
      chk({tag, "_partial_accepts"}, 64'(k), 64'(stop_at));
      return;
    end
    chk({tag, "_accepts"}, 64'(k), 64'(n));
    if (mode == 0) chk({tag, "_consecutive_cycles"}, 64'(cyc), 64'(n));
    // One cycle after the last accept: START.
    chk({tag, "_padding_start"}, 64'(padding_start), 64'd1);
    chk({tag, "_final_wr_en"}, 64'(buffer_wr_en), 64'd1);
    chk({tag, "_ready_after_last"}, 64'(s_ready), 64'd0);
    step();
    chk({tag, "_padding_start_pulse"}, 64'(padding_start), 64'd0);
    chk({tag, "_busy_wait"}, 64'(write_busy), 64'd1);
    step();
    step();
    chk({tag, "_no_extra_writes"}, 64'(wq.size()), 64'(n));
    padding_finish = 1'b1;
    step();
    padding_finish = 1'b0;
    s_valid = 1'b0;
    chk({tag, "_write_finish"}, 64'(write_finish), 64'd1);
    chk({tag, "_busy_idle"}, 64'(write_busy), 64'd0);
    step();
    chk({tag, "_write_finish_pulse"}, 64'(write_finish), 64'd0);
    for (int i = 0; i < wq.size(); i++)
      if (wq[i] !== base + 64'(i)) data_bad = 1'b1;
    chk({tag, "_data_order"}, 64'(data_bad), 64'd0);
  endtask

  initial begin
    #23;
    chk("rst_wr_en", 64'(buffer_wr_en), 64'd0);
    chk("rst_wr_data", buffer_wr_data, 64'd0);
    chk("rst_busy", 64'(write_busy), 64'd0);
    chk("rst_ready", 64'(s_ready), 64'd0);
    chk("rst_counts", {48'd0, wr_row_cnt, wr_col_cnt}, 64'd0);
    chk("rst_err", 64'(wr_err), 64'd0);
    step();
    s_rst_n = 1'b1;
    step();

    run_batch("t1_w13_r2", 3'd5, 7'd2, 13, 64'h1000, 0, 0, 1'b0);
    run_batch("t2_w416_full", 3'd0, 7'd0, 416, 64'h2000, 1, 0, 1'b0);
    run_batch("t3_w52_gaps", 3'd3, 7'd5, 52, 64'h3000, 2, 0, 1'b0);
    run_batch("t4_ignored", 3'd5, 7'd0, 13, 64'h4000, 0, 0, 1'b1);
    chk("t4_wr_err", 64'(wr_err), 64'(ERR_EXP));

    run_batch("t5_partial", 3'd0, 7'd1, 416, 64'h5000, 0, 100, 1'b0);
    chk("t5_wr_en_before_rst", 64'(buffer_wr_en), 64'd1);
    s_rst_n = 1'b0;
    #1;
    chk("t5_rst_wr_en", 64'(buffer_wr_en), 64'd0);
    chk("t5_rst_busy", 64'(write_busy), 64'd0);
    chk("t5_rst_ready", 64'(s_ready), 64'd0);
    chk("t5_rst_counts", {48'd0, wr_row_cnt, wr_col_cnt}, 64'd0);
    chk("t5_rst_err", 64'(wr_err), 64'd0);
    s_valid = 1'b0;
    step();
    s_rst_n = 1'b1;
    step();
    run_batch("t5_clean", 3'd2, 7'd1, 104, 64'h6000, 0, 0, 1'b0);

    run_batch("t6_w26", 3'd4, 7'd0, 26, 64'h7000, 0, 0, 1'b0);
    run_batch("t6_w208", 3'd1, 7'd0, 208, 64'h8000, 0, 0, 1'b0);
    chk("t6_err_after_reset", 64'(wr_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
